// File: rtl/quadrature_pkg.sv
// Shared types and helpers for the quadrature volume front end.
// Combinational only; no latency or flow control.
// Position decode, step encoding and parameter legality checks.
package quadrature_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ERR  = 2'd3
    } step_t;

    // Gray order 00,01,11,10 maps onto 0..3 by a Gray-to-binary conversion.
    function automatic logic [1:0] gray_index(input logic [1:0] pos);
        return {pos[1], pos[1] ^ pos[0]};
    endfunction

    function automatic logic [1:0] binary_index(input logic [1:0] pos);
        return pos;
    endfunction

    function automatic logic [1:0] pos_index(input logic [1:0] pos, input logic gray);
        return gray ? gray_index(pos) : binary_index(pos);
    endfunction

    function automatic step_t decode_step(input logic [1:0] old_pos, input logic [1:0] new_pos,
                                          input logic gray);
        logic [1:0] delta;
        step_t      step;
        delta = pos_index(new_pos, gray) - pos_index(old_pos, gray);
        case (delta)
            2'd1:    step = STEP_UP;
            2'd3:    step = STEP_DOWN;
            2'd2:    step = STEP_ERR;
            default: step = STEP_NONE;
        endcase
        return step;
    endfunction

    function automatic bit params_ok(input int detent, input int filter,
                                     input int vol_init, input int vol_max);
        return (detent == 1 || detent == 2 || detent == 4) &&
               (filter >= 1) && (filter <= 15) && (vol_init <= vol_max);
    endfunction

endpackage

// File: rtl/quadrature_channel.sv
// One encoder channel: glitch filter, direction decode, detent accumulator, volume.
// Outputs register one cycle after the accepting sample tick.
// No backpressure; pulses are fire-and-forget.
module quadrature_channel
    import quadrature_pkg::*;
#(
    parameter int FILTER   = 2,
    parameter int DETENT   = 4,
    parameter int GRAY     = 1,
    parameter int VOL_BITS = 8,
    parameter int VOL_MAX  = 255,
    parameter int VOL_INIT = 128
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                tick,
    input  logic [1:0]          sample,
    input  logic                clear,
    output logic                up,
    output logic                down,
    output logic                error,
    output logic [VOL_BITS-1:0] volume
);

    localparam logic [3:0]          FILT     = 4'(FILTER);
    localparam logic signed [3:0]   ACC_TOP  = $signed(4'(DETENT - 1));
    localparam logic [VOL_BITS-1:0] V_MAX    = VOL_BITS'(VOL_MAX);
    localparam logic [VOL_BITS-1:0] V_INIT   = VOL_BITS'(VOL_INIT);

    logic [1:0]        candidate, stable, cand_nx;
    logic [3:0]        run, run_nx;
    logic              valid, accept;
    logic signed [3:0] acc;
    step_t             step;

    always_comb begin
        cand_nx = candidate;
        run_nx  = run;
        step    = STEP_NONE;
        if (sample == candidate) begin
            run_nx = (run >= FILT) ? FILT : run + 4'd1;
        end else begin
            cand_nx = sample;
            run_nx  = 4'd1;
        end
        // The first settled state after reset only seeds stable; it is not a step.
        accept = tick && (run_nx == FILT) && (!valid || cand_nx != stable);
        if (accept && valid)
            step = decode_step(stable, cand_nx, GRAY != 0);
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            candidate <= 2'b00;
            run       <= 4'd0;
            stable    <= 2'b00;
            valid     <= 1'b0;
            acc       <= 4'sd0;
            volume    <= V_INIT;
            up        <= 1'b0;
            down      <= 1'b0;
            error     <= 1'b0;
        end else begin
            up    <= 1'b0;
            down  <= 1'b0;
            error <= (step == STEP_ERR);
            if (tick) begin
                candidate <= cand_nx;
                run       <= run_nx;
            end
            if (accept) begin
                stable <= cand_nx;
                valid  <= 1'b1;
            end
            if (clear) begin
                acc    <= 4'sd0;
                volume <= V_INIT;
            end else if (step == STEP_UP) begin
                if (acc == ACC_TOP) begin
                    acc <= 4'sd0;
                    up  <= 1'b1;
                    if (volume < V_MAX)
                        volume <= volume + VOL_BITS'(1);
                end else begin
                    acc <= acc + 4'sd1;
                end
            end else if (step == STEP_DOWN) begin
                if (acc == -ACC_TOP) begin
                    acc  <= 4'sd0;
                    down <= 1'b1;
                    if (volume != '0)
                        volume <= volume - VOL_BITS'(1);
                end else begin
                    acc <= acc - 4'sd1;
                end
            end
        end
    end

endmodule

// File: rtl/quadrature_volume.sv
// Multi-channel quadrature encoder volume control: synchronisers, shared prescaler, channels.
// Input reaches the filter after 2 cycles; events appear one cycle after the accepting tick.
// No backpressure; all outputs are unconditional pulses or levels.
module quadrature_volume
    import quadrature_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_BITS = 20,
    parameter int FILTER      = 2,
    parameter int DETENT      = 4,
    parameter int GRAY        = 1,
    parameter int VOL_BITS    = 8,
    parameter int VOL_MAX     = 255,
    parameter int VOL_INIT    = 128
) (
    input  logic                         Clk,
    input  logic                         nReset,
    input  logic [2*CHANNELS-1:0]        Input,
    input  logic [CHANNELS-1:0]          Clear,
    output logic [CHANNELS-1:0]          Up,
    output logic [CHANNELS-1:0]          Down,
    output logic [CHANNELS-1:0]          Error,
    output logic [CHANNELS*VOL_BITS-1:0] Volume
);

    generate
        if (!params_ok(DETENT, FILTER, VOL_INIT, VOL_MAX)) begin : g_bad_params
            $error("quadrature_volume: illegal DETENT/FILTER/VOL_INIT parameters");
        end
    endgenerate

    logic [2*CHANNELS-1:0]  sync_a, sync_b;
    logic [SAMPLE_BITS-1:0] prescale;
    logic                   tick;

    assign tick = &prescale;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            prescale <= '0;
        end else begin
            sync_a   <= Input;
            sync_b   <= sync_a;
            prescale <= prescale + SAMPLE_BITS'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        quadrature_channel #(
            .FILTER   (FILTER),
            .DETENT   (DETENT),
            .GRAY     (GRAY),
            .VOL_BITS (VOL_BITS),
            .VOL_MAX  (VOL_MAX),
            .VOL_INIT (VOL_INIT)
        ) u_chan (
            .Clk    (Clk),
            .nReset (nReset),
            .tick   (tick),
            .sample (sync_b[2*c +: 2]),
            .clear  (Clear[c]),
            .up     (Up[c]),
            .down   (Down[c]),
            .error  (Error[c]),
            .volume (Volume[VOL_BITS*c +: VOL_BITS])
        );
    end

endmodule

// File: tb/tb_quadrature_volume.sv
// Bench for quadrature_volume: directed table, floor/ceiling sweeps, random scoreboard.
module tb_quadrature_volume;

    localparam int FILT  = 2;
    localparam int DET   = 4;
    localparam int VMAX  = 255;
    localparam int VINIT = 128;
    localparam int TPER  = 16;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [3:0]  Input;
    logic [1:0]  Clear;
    logic [1:0]  Up, Down, Error;
    logic [15:0] Volume;

    quadrature_volume #(
        .CHANNELS(2), .SAMPLE_BITS(4), .FILTER(FILT), .DETENT(DET), .GRAY(1),
        .VOL_BITS(8), .VOL_MAX(VMAX), .VOL_INIT(VINIT)
    ) dut (
        .Clk(Clk), .nReset(nReset), .Input(Input), .Clear(Clear),
        .Up(Up), .Down(Down), .Error(Error), .Volume(Volume)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc;

    logic [1:0] seq [4];
    logic [1:0] m_cand [2];
    logic [1:0] m_stable [2];
    int         m_run [2];
    bit         m_valid [2];
    int         m_acc [2];
    int         m_vol [2];
    logic [1:0] e_up, e_dn, e_er;
    int         cnt_up [2];
    int         cnt_dn [2];
    int         cnt_er [2];

    typedef struct {
        logic [3:0] inp;
        logic [1:0] clr;
        int ticks;
        int up0, dn0, er0, up1;
        int vol0, vol1;
    } vec_t;
    vec_t tbl [35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pos_of(input logic [1:0] p);
        for (int i = 0; i < 4; i++)
            if (seq[i] == p) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cand[c] = 2'b00; m_stable[c] = 2'b00; m_run[c] = 0;
            m_valid[c] = 0; m_acc[c] = 0; m_vol[c] = VINIT;
        end
        e_up = 0; e_dn = 0; e_er = 0;
    endtask

    task automatic model_tick(input logic [1:0] clr);
        e_up = 0; e_dn = 0; e_er = 0;
        for (int c = 0; c < 2; c++) begin
            logic [1:0] s;
            int step, d;
            s = Input[2*c +: 2];
            step = 0;
            if (s == m_cand[c]) m_run[c] = (m_run[c] >= FILT) ? FILT : m_run[c] + 1;
            else begin m_cand[c] = s; m_run[c] = 1; end
            if (m_run[c] == FILT && (!m_valid[c] || m_cand[c] != m_stable[c])) begin
                if (m_valid[c]) begin
                    d = (pos_of(m_cand[c]) - pos_of(m_stable[c]) + 4) % 4;
                    if (d == 1) step = 1;
                    else if (d == 3) step = -1;
                    else if (d == 2) e_er[c] = 1'b1;
                end
                m_stable[c] = m_cand[c];
                m_valid[c] = 1;
            end
            if (clr[c]) begin
                m_acc[c] = 0; m_vol[c] = VINIT;
            end else if (step != 0) begin
                m_acc[c] += step;
                if (m_acc[c] == DET) begin
                    m_acc[c] = 0; e_up[c] = 1'b1;
                    if (m_vol[c] < VMAX) m_vol[c]++;
                end else if (m_acc[c] == -DET) begin
                    m_acc[c] = 0; e_dn[c] = 1'b1;
                    if (m_vol[c] > 0) m_vol[c]--;
                end
            end
        end
    endtask

    // Clear is presented only during the tick cycle so it lands on the sampling edge.
    task automatic run_ticks(input int n, input logic [1:0] clr);
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < TPER; k++) begin
                @(posedge Clk); #1;
                cyc++;
                if (cyc % TPER == 0) begin
                    model_tick(clr);
                    Clear = 2'b00;
                end else begin
                    e_up = 0; e_dn = 0; e_er = 0;
                end
                check("outputs", {10'd0, Up, Down, Error, Volume},
                      {10'd0, e_up, e_dn, e_er, 8'(m_vol[1]), 8'(m_vol[0])});
                for (int c = 0; c < 2; c++) begin
                    cnt_up[c] += int'(Up[c]); cnt_dn[c] += int'(Down[c]); cnt_er[c] += int'(Error[c]);
                end
                if (cyc % TPER == TPER - 1) Clear = clr;
            end
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 2; c++) begin cnt_up[c] = 0; cnt_dn[c] = 0; cnt_er[c] = 0; end
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        nReset = 1'b0; Clear = 2'b00;
        repeat (2) @(posedge Clk);
        #1;
        check("reset pulses", {26'd0, Up, Down, Error}, 32'd0);
        check("reset volume", {16'd0, Volume}, {16'd0, 8'(VINIT), 8'(VINIT)});
        nReset = 1'b1;
        cyc = 0;
        model_reset();
    endtask

    task automatic detents(input int c, input bit up, input int n);
        for (int i = 0; i < n; i++)
            for (int k = 1; k <= 4; k++) begin
                Input[2*c +: 2] = up ? seq[k % 4] : seq[(4 - k) % 4];
                run_ticks(2, 2'b00);
            end
    endtask

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        //            inp     clr    tk up0 dn0 er0 up1 vol0 vol1
        tbl[0]  = '{4'b0000, 2'b00, 2, 0, 0, 0, 0, 128, 128};
        tbl[1]  = '{4'b0001, 2'b00, 3, 0, 0, 0, 0, 128, 128};
        tbl[2]  = '{4'b0011, 2'b00, 3, 0, 0, 0, 0, 128, 128};
        tbl[3]  = '{4'b0010, 2'b00, 3, 0, 0, 0, 0, 128, 128};
        tbl[4]  = '{4'b0000, 2'b00, 3, 1, 0, 0, 0, 129, 128};
        tbl[5]  = '{4'b0001, 2'b00, 1, 0, 0, 0, 0, 129, 128};
        tbl[6]  = '{4'b0000, 2'b00, 3, 0, 0, 0, 0, 129, 128};
        tbl[7]  = '{4'b0011, 2'b00, 3, 0, 0, 1, 0, 129, 128};
        tbl[8]  = '{4'b0000, 2'b00, 3, 0, 0, 1, 0, 129, 128};
        tbl[9]  = '{4'b0001, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[10] = '{4'b0011, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[11] = '{4'b0010, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[12] = '{4'b0011, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[13] = '{4'b0001, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[14] = '{4'b0000, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[15] = '{4'b0001, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[16] = '{4'b0011, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[17] = '{4'b0010, 2'b00, 2, 0, 0, 0, 0, 129, 128};
        tbl[18] = '{4'b0000, 2'b00, 2, 1, 0, 0, 0, 130, 128};
        tbl[19] = '{4'b0100, 2'b00, 2, 0, 0, 0, 0, 130, 128};
        tbl[20] = '{4'b1100, 2'b00, 2, 0, 0, 0, 0, 130, 128};
        tbl[21] = '{4'b1000, 2'b00, 2, 0, 0, 0, 0, 130, 128};
        tbl[22] = '{4'b0000, 2'b00, 2, 0, 0, 0, 1, 130, 129};
        tbl[23] = '{4'b0100, 2'b00, 2, 0, 0, 0, 0, 130, 129};
        tbl[24] = '{4'b1100, 2'b00, 2, 0, 0, 0, 0, 130, 129};
        tbl[25] = '{4'b1000, 2'b00, 2, 0, 0, 0, 0, 130, 129};
        tbl[26] = '{4'b0000, 2'b10, 2, 0, 0, 0, 0, 130, 128};
        tbl[27] = '{4'b0101, 2'b00, 2, 0, 0, 0, 0, 130, 128};
        tbl[28] = '{4'b1111, 2'b00, 2, 0, 0, 0, 0, 130, 128};
        tbl[29] = '{4'b1010, 2'b00, 2, 0, 0, 0, 0, 130, 128};
        tbl[30] = '{4'b0000, 2'b00, 2, 1, 0, 0, 1, 131, 129};
        tbl[31] = '{4'b0001, 2'b00, 2, 0, 0, 0, 0, 131, 129};
        tbl[32] = '{4'b0000, 2'b01, 2, 0, 0, 0, 0, 128, 129};
        tbl[33] = '{4'b0010, 2'b00, 2, 0, 0, 0, 0, 128, 129};
        tbl[34] = '{4'b0000, 2'b00, 2, 0, 0, 0, 0, 128, 129};

        nReset = 1'b0; Input = 4'b0000; Clear = 2'b00; cyc = 0;
        clear_counts();
        do_reset();

        for (int i = 0; i < 35; i++) begin
            Input = tbl[i].inp;
            clear_counts();
            run_ticks(tbl[i].ticks, tbl[i].clr);
            check($sformatf("row%0d up0", i), cnt_up[0], tbl[i].up0);
            check($sformatf("row%0d dn0", i), cnt_dn[0], tbl[i].dn0);
            check($sformatf("row%0d er0", i), cnt_er[0], tbl[i].er0);
            check($sformatf("row%0d up1", i), cnt_up[1], tbl[i].up1);
            check($sformatf("row%0d vol0", i), Volume[7:0], tbl[i].vol0);
            check($sformatf("row%0d vol1", i), Volume[15:8], tbl[i].vol1);
        end

        // Floor: 128 detents reach zero, one more still pulses.
        clear_counts();
        detents(0, 1'b0, 129);
        check("floor down count", cnt_dn[0], 129);
        check("floor up count", cnt_up[0], 0);
        check("floor volume", Volume[7:0], 0);

        // Ceiling: clear back to 128, then 127 detents up, then one saturated.
        run_ticks(1, 2'b01);
        check("clear volume", Volume[7:0], VINIT);
        clear_counts();
        detents(0, 1'b1, 127);
        check("ceiling up count", cnt_up[0], 127);
        check("ceiling volume", Volume[7:0], VMAX);
        clear_counts();
        detents(0, 1'b1, 1);
        check("saturated up pulse", cnt_up[0], 1);
        check("saturated volume", Volume[7:0], VMAX);

        for (int i = 0; i < 120; i++) begin
            logic [1:0] clr;
            Input = {seq[$urandom_range(0, 3)], seq[$urandom_range(0, 3)]};
            clr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_ticks($urandom_range(1, 3), clr);
        end

        // Reset in the middle of filtering: the next settled state is a reload.
        Input = 4'b0000;
        run_ticks(3, 2'b00);
        Input = 4'b0101;
        run_ticks(1, 2'b00);
        do_reset();
        clear_counts();
        run_ticks(3, 2'b00);
        check("post-reset up", cnt_up[0] + cnt_up[1], 0);
        check("post-reset down", cnt_dn[0] + cnt_dn[1], 0);
        check("post-reset error", cnt_er[0] + cnt_er[1], 0);
        Input = 4'b1111;
        clear_counts();
        run_ticks(3, 2'b00);
        check("post-reset step no pulse", cnt_up[0] + cnt_up[1], 0);
        check("post-reset volume", {16'd0, Volume}, {16'd0, 8'(VINIT), 8'(VINIT)});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quadrature_volume.md
# quadrature_volume

Multi-channel quadrature rotary-encoder front end for the amplifier's front-panel and remote volume controls. Each channel synchronises and glitch-filters a 2-bit encoder input on a shared slow sample tick, decodes direction in Gray or binary sequence mode, and accumulates sub-steps into detents. Each channel emits one-cycle Up/Down pulses plus a saturating volume register. Each channel also flags illegal two-step jumps.

## Interface

- CHANNELS, 2: number of independent encoders.
- SAMPLE_BITS, 20: prescaler width; one sample tick every 2^SAMPLE_BITS clocks (~21 ms at 50 MHz).
- FILTER, 2: consecutive identical samples required before a new input state is accepted (1..15).
- DETENT, 4: valid steps per Up/Down event (1, 2 or 4).
- GRAY, 1: 1 selects sequence 00→01→11→10→00; 0 selects 00→01→10→11→00 as the up direction.
- VOL_BITS, 8: volume register width.
- VOL_MAX, 255: upper saturation limit.
- VOL_INIT, 128: value after reset and Clear.

- Clk  in  1  system clock, 50 MHz.
- nReset  in  1  synchronous reset, active-low. One clock; all state samples nReset on posedge Clk.
- Input  in  2*CHANNELS  raw encoder bits; channel c on [2c+1:2c]; asynchronous.
- Clear  in  CHANNELS  per-channel synchronous clear of accumulator and volume.
- Up  out  CHANNELS  one-cycle pulse per detent in the up direction.
- Down  out  CHANNELS  one-cycle pulse per detent in the down direction.
- Error  out  CHANNELS  one-cycle pulse on a two-step (illegal) transition.
- Volume  out  CHANNELS*VOL_BITS  per-channel volume; channel c on [VOL_BITS*(c+1)-1:VOL_BITS*c].

## Operation

- Synchroniser: every Input bit passes through 2 flops before use.
- Prescaler: a free-running SAMPLE_BITS counter. Tick is asserted for one cycle when the count is all ones.
- Filter, per channel, on tick:
  - If sample == Candidate, Run = min(Run+1, FILTER).
  - Otherwise Candidate = sample and Run = 1.
  - When Run reaches FILTER and Candidate != Stable, Stable takes Candidate and one transition (Old=Stable, New=Candidate) is decoded.
- First acceptance after reset: Valid=0 until then. The first accepted state loads Stable and sets Valid=1, with no decode and no Error.
- Decode: positions are mapped to an index 0..3 per GRAY. delta = (New − Old) mod 4.
  - delta 1: +1 step.
  - delta 3: −1 step.
  - delta 2: Error pulse; accumulator unchanged.
- Accumulator: signed, range −(DETENT−1)..+(DETENT−1).
  - On +1 at +(DETENT−1): Up pulse, Acc=0. Otherwise Acc+1.
  - On −1 at −(DETENT−1): Down pulse, Acc=0. Otherwise Acc−1.
  - A reversal moves Acc back toward 0 and emits no event.
- Volume:
  - On Up: Volume = min(Volume+1, VOL_MAX).
  - On Down: Volume = max(Volume−1, 0).
  - The Up/Down pulse is emitted even when Volume is saturated.
- Clear[c]: Acc=0 and Volume=VOL_INIT. Clear beats a simultaneous step; the Up/Down pulse from that step is suppressed. Filter state is untouched.

## Timing

- Reset values:
  - Up, Down, Error = 0.
  - Volume = VOL_INIT.
  - Prescaler, Acc, Run = 0.
  - Valid = 0.
- Reset mid-operation discards any partially filtered state. The next accepted state after reset is a reload, not a step.
- Input to Stable latency: 2 synchroniser cycles, plus the remaining prescaler wait, plus (FILTER−1) further ticks.
- Up/Down/Error assert on the cycle after the tick that accepts the state, for exactly one cycle. Volume updates on that same cycle.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Up and Down never assert together on one channel.
- A bounce shorter than FILTER ticks never changes Stable.

## Structure

- Package quadrature_pkg:
  - Position-to-index functions for GRAY=0/1.
  - Step type encoding none/up/down/error.
  - Parameter legality checks: DETENT in {1,2,4}, FILTER ≥ 1, VOL_INIT ≤ VOL_MAX.
- Sub-module quadrature_channel holds the filter, decoder, accumulator and volume register for one channel. It is instantiated CHANNELS times with a generate loop.
- The top level owns the synchronisers and the shared prescaler.

## Test plan

Bench uses SAMPLE_BITS=4, FILTER=2, DETENT=4, GRAY=1, CHANNELS=2.

- Reset, then hold Input0=00 → no pulses; Volume0=128; after 2 ticks Valid set with no Error.
- Channel 0 steps 00→01→11→10→00, each state held 3 ticks → exactly one Up0 pulse after the 4th step; Volume0=129; Acc=0.
- Down at floor: Clear, then 128 down detents, then 1 more → Volume0=0; Down0 still pulses on the last detent.
- Up at ceiling: 127 up detents from 128 → Volume0=255, with Up0 pulsing on each detent.
- Glitch: hold 00, apply 01 for 1 tick, then return to 00 → no change to Stable; no pulses. Separately apply 00→11 → one Error0 pulse; Volume unchanged.
- Reversal and concurrency:
  - Ch0 does +3 steps then −3 steps → no pulses; Acc=0.
  - Ch1 does one up detent while Clear[1] asserts on the accept cycle → Up1 suppressed; Volume1=128.
  - Ch0 and Ch1 complete up detents on the same tick → both Up pulses in the same cycle.
